memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Memory (M) stage of the 5-stage RISC-V pipeline: holds the E→M pipeline register and drives a variable-latency data-memory port with a req/ack handshake. It also formats load data, generates store byte enables, and presents the M-stage signals that the writeback stage registers. Wait states, misaligned accesses and bus timeouts are handled here. Stalls are reported to the hazard unit via `StallM`.

## Interface
Parameters:
- `word_width`, 32, datapath width; only 32 is supported.
- `timeout_cycles`, 255, maximum number of WAIT cycles before a bus error; counter width is 8 bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `RegWriteE`, `MemWriteE`  in  1  register-write and store controls from execute.
- `ResultSrcE`  in  2  result select; `01` marks a load.
- `funct3E`  in  3  load/store size and sign.
- `ALUResultE`  in  32  effective address or ALU result.
- `WriteDataE`  in  32  store data (rs2).
- `PCPlus4E`  in  32  PC + 4.
- `RdE`  in  5  destination register.
- `RegWriteM`  out  1  register-write to writeback; forced to 0 on bubble, stall or fault.
- `ResultSrcM`  out  2  registered result select.
- `ALUResultM`, `PCPlus4M`  out  32  registered values.
- `ReadDataM`  out  32  formatted load data; 0 unless a load completes this cycle.
- `RdM`  out  5  registered destination.
- `StallM`  out  1  M stage is not completing this cycle; freezes the F/D/E stages.
- `MisalignedM`, `BusErrorM`  out  1  one-cycle fault pulses.
- `dmem_req`, `dmem_we`  out  1  memory request and write enable.
- `dmem_addr`  out  32  word-aligned address: `{ALUResult[31:2],2'b00}`.
- `dmem_wdata`  out  32  store data replicated across byte lanes.
- `dmem_be`  out  4  byte enables.
- `dmem_rdata`  in  32  read data; valid when `dmem_ack`=1.
- `dmem_ack`  in  1  access complete; may be asserted in the same cycle as `dmem_req`.

## Operation
- **E→M register.** Loads all E inputs on each edge when `StallM`=0. Holds when `StallM`=1.
- **Memory op.** A load (`ResultSrc`=01) or a store (`MemWrite`=1). Other instructions pass through with `StallM`=0 and `ReadDataM`=0.
- **Byte lane.** `a=ALUResult[1:0]`.
- **Loads.**
  - 000 LB: sign-extends byte `a`.
  - 001 LH: sign-extends half `a[1]`.
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extended.
- **Stores.**
  - SB: `be=0001<<a`, `wdata={4{b}}`.
  - SH: `be=0011<<{a[1],1'b0}`, `wdata={2{h}}`.
  - SW: `be=1111`.
- **Misaligned or unsupported access.** Applies to a half access with `a[0]`=1, a word access with `a`≠0, or an unsupported funct3.
  - No request is issued.
  - `MisalignedM`=1 for one cycle and `RegWriteM`=0.
  - The instruction retires as a bubble and `StallM`=0.
- **FSM IDLE.** An aligned memory op drives `dmem_req`=1.
  - If `dmem_ack`=1: the op completes this cycle.
  - Otherwise: `StallM`=1, `RegWriteM`=0, go to WAIT, `cnt`=0.
- **FSM WAIT.** `dmem_req` stays high with addr/we/wdata/be stable.
  - If `dmem_ack`=1: the op completes and the FSM returns to IDLE.
  - Otherwise `cnt++`. When `cnt` = `timeout_cycles`−1 with no ack:
    - `BusErrorM`=1 and the op retires as a bubble (`RegWriteM`=0).
    - `StallM`=0 and the FSM returns to IDLE.
    - `dmem_req` is low on the following cycle.
- **Completion cycle.** `StallM`=0 and `RegWriteM`=`RegWrite` register. For a load, `ReadDataM` is formatted `dmem_rdata`.
- **Bubbles during a stall.** While `StallM`=1, writeback samples a bubble each cycle, so there is no double commit.

## Timing
- **Reset.** All register contents become 0 (`RegWriteM`, `MemWrite`, `ResultSrcM`, `ALUResultM`, `PCPlus4M`, `RdM`). Also: state=IDLE, `cnt`=0, `dmem_req`=0, `StallM`=0, both fault flags 0.
- **Zero-wait memory.** Every instruction occupies M for 1 cycle with no stall.
- **k wait states.** A memory op occupies M for k+1 cycles, with `StallM`=1 for the first k.
- **Timeout.** `StallM` is high for `timeout_cycles` cycles; the bus-error cycle has `StallM`=0.
- **Combinational paths.** `dmem_req`, `StallM`, `RegWriteM` and `ReadDataM` depend combinationally on `dmem_ack` and `dmem_rdata` in the current cycle.
- **Reset during WAIT.** The request is abandoned; `dmem_req`=0 from the cycle after reset is sampled. An ack arriving while reset=1, or in IDLE with no request, is ignored.
- **Back-to-back memory ops.** A new op enters M on the edge where the previous one completes. Its request may assert in the very next cycle.

## Test plan
- **Reset.** Assert `reset` during WAIT → next cycle `dmem_req`=0, `StallM`=0, all M outputs 0.
- **LB/LBU, zero-wait.** Load from addr 0x103 with `dmem_rdata`=0x80FF_FF12, `ack` same cycle → LB `ReadDataM`=0xFFFF_FF80; LBU gives 0x0000_0080. Both with `StallM`=0 and `RegWriteM`=1.
- **SH, 3 wait states.** SH to addr 0x206, data 0xABCD → `dmem_be`=1100, `dmem_wdata`=0xABCD_ABCD, `dmem_addr`=0x204. `StallM`=1 for 3 cycles, then the op completes and the E input is held throughout.
- **Misaligned.** LW at addr 0x0000_0102 → `MisalignedM`=1 for 1 cycle, no `dmem_req`, `RegWriteM`=0, no stall.
- **Timeout.** Load with `timeout_cycles`=4 and `ack` never asserted → `StallM`=1 for 4 cycles, then `BusErrorM`=1 with `RegWriteM`=0, then `dmem_req`=0.
- **Mixed stream.** ADD, LW (1 wait), SW (0 wait), ADD → the ADDs pass with `StallM`=0. The LW stalls 1 cycle and commits once; the SW has `be`=1111 and 0 stalls.

Source files
------------

// File: rtl/memory_access_stage.sv
// Memory stage: E->M pipeline register, data-memory req/ack port,
// load formatting, store lane steering and misalign/timeout faults.
module memory_access_stage #(
    parameter int word_width     = 32,
    parameter int timeout_cycles = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic [2:0]            funct3E,
    input  logic [word_width-1:0] ALUResultE,
    input  logic [word_width-1:0] WriteDataE,
    input  logic [word_width-1:0] PCPlus4E,
    input  logic [4:0]            RdE,
    output logic                  RegWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [word_width-1:0] ALUResultM,
    output logic [word_width-1:0] PCPlus4M,
    output logic [word_width-1:0] ReadDataM,
    output logic [4:0]            RdM,
    output logic                  StallM,
    output logic                  MisalignedM,
    output logic                  BusErrorM,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [word_width-1:0] dmem_addr,
    output logic [word_width-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [word_width-1:0] dmem_rdata,
    input  logic                  dmem_ack
);

    localparam logic [0:0] s_idle   = 1'b0;
    localparam logic [0:0] s_wait   = 1'b1;
    localparam logic [7:0] last_cnt = 8'(timeout_cycles - 1);

    logic                  regwrite_r;
    logic                  memwrite_r;
    logic [2:0]            funct3_r;
    logic [word_width-1:0] wdata_r;
    logic [0:0]            state;
    logic [7:0]            cnt;

    logic       is_load;
    logic       is_store;
    logic       mem_op;
    logic       bad;
    logic       go;
    logic       last;
    logic       timeout;
    logic [1:0] a;
    logic [31:0] shifted;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] fmt;

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_r <= 1'b0;
            memwrite_r <= 1'b0;
            ResultSrcM <= 2'b00;
            funct3_r   <= 3'b000;
            ALUResultM <= '0;
            wdata_r    <= '0;
            PCPlus4M   <= '0;
            RdM        <= 5'd0;
        end else if (!StallM) begin
            regwrite_r <= RegWriteE;
            memwrite_r <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            funct3_r   <= funct3E;
            ALUResultM <= ALUResultE;
            wdata_r    <= WriteDataE;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
        end
    end

    assign a        = ALUResultM[1:0];
    assign is_store = memwrite_r;
    assign is_load  = (ResultSrcM == 2'b01) & ~memwrite_r;
    assign mem_op   = is_load | is_store;

    // Unsigned sizes exist only for loads; reserved funct3 codes fault.
    always_comb begin
        bad = 1'b0;
        case (funct3_r)
            3'b000:         bad = 1'b0;
            3'b001:         bad = a[0];
            3'b010:         bad = (a != 2'b00);
            3'b100, 3'b101: bad = is_store | (funct3_r[0] & a[0]);
            default:        bad = 1'b1;
        endcase
    end

    assign go      = mem_op & ~bad;
    assign last    = (state == s_wait) && (cnt == last_cnt);
    assign timeout = go & ~dmem_ack & last;

    assign StallM      = go & ~dmem_ack & ~last;
    assign MisalignedM = mem_op & bad;
    assign BusErrorM   = timeout;
    assign RegWriteM   = regwrite_r & ~StallM & ~MisalignedM & ~timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= s_idle;
            cnt   <= 8'd0;
        end else begin
            case (state)
                s_idle: begin
                    if (go && !dmem_ack) begin
                        state <= s_wait;
                        cnt   <= 8'd0;
                    end
                end
                default: begin
                    if (dmem_ack || last) begin
                        state <= s_idle;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign shifted = dmem_rdata >> {a, 3'b000};
    assign rbyte   = shifted[7:0];
    assign rhalf   = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        fmt = dmem_rdata;
        case (funct3_r)
            3'b000:  fmt = {{24{rbyte[7]}}, rbyte};
            3'b001:  fmt = {{16{rhalf[15]}}, rhalf};
            3'b100:  fmt = {24'd0, rbyte};
            3'b101:  fmt = {16'd0, rhalf};
            default: fmt = dmem_rdata;
        endcase
    end

    assign ReadDataM = (is_load && go && dmem_ack) ? fmt : '0;

    assign dmem_req  = go;
    assign dmem_we   = go & is_store;
    assign dmem_addr = {ALUResultM[31:2], 2'b00};

    always_comb begin
        dmem_wdata = wdata_r;
        dmem_be    = 4'b0000;
        case (funct3_r[1:0])
            2'b00: begin
                dmem_wdata = {4{wdata_r[7:0]}};
                dmem_be    = 4'b0001 << a;
            end
            2'b01: begin
                dmem_wdata = {2{wdata_r[15:0]}};
                dmem_be    = 4'b0011 << {a[1], 1'b0};
            end
            default: begin
                dmem_wdata = wdata_r;
                dmem_be    = 4'b1111;
            end
        endcase
        if (!go)
            dmem_be = 4'b0000;
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: ops and their expected
// results are queued at issue and compared when each op leaves M.
module tb_memory_access_stage;

    typedef struct {
        logic rw; logic mw; logic [1:0] rs; logic [2:0] f3;
        logic [31:0] alu; logic [31:0] wd; logic [31:0] pc4;
        logic [4:0] rd; int ack_at; logic [31:0] rdata;
    } op_t;

    typedef struct {
        logic rw; logic [1:0] rs; logic [31:0] alu; logic [31:0] pc4;
        logic [4:0] rd; logic [31:0] rdata; logic mis; logic berr;
        int stalls; logic req; logic we; logic [3:0] be;
        logic [31:0] wd; logic [31:0] addr;
    } exp_t;

    logic        clk = 0;
    logic        reset;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  funct3E;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, PCPlus4M, ReadDataM;
    logic [4:0]  RdM;
    logic        StallM, MisalignedM, BusErrorM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;

    int checks = 0;
    int errors = 0;
    int commits = 0;
    logic [31:0] pc = 32'h1000;

    op_t  ops_q[$];
    exp_t exps_q[$];
    exp_t sb[$];

    memory_access_stage #(.word_width(32), .timeout_cycles(4)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .funct3E(funct3E),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .PCPlus4E(PCPlus4E), .RdE(RdE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M),
        .ReadDataM(ReadDataM), .RdM(RdM), .StallM(StallM),
        .MisalignedM(MisalignedM), .BusErrorM(BusErrorM),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic drive(input op_t o);
        RegWriteE = o.rw; MemWriteE = o.mw; ResultSrcE = o.rs;
        funct3E = o.f3; ALUResultE = o.alu; WriteDataE = o.wd;
        PCPlus4E = o.pc4; RdE = o.rd;
    endtask

    task automatic drive_nop();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; funct3E = 0;
        ALUResultE = 0; WriteDataE = 0; PCPlus4E = 0; RdE = 0;
    endtask

    task automatic add(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input int ack_at, input logic [31:0] rdata,
                       input logic erw, input logic [31:0] erdata,
                       input logic emis, input logic eberr, input int estalls,
                       input logic ereq, input logic ewe, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic [31:0] eaddr);
        op_t o; exp_t e;
        pc = pc + 4;
        o.rw = rw; o.mw = mw; o.rs = rs; o.f3 = f3; o.alu = alu; o.wd = wd;
        o.pc4 = pc; o.rd = rd; o.ack_at = ack_at; o.rdata = rdata;
        e.rw = erw; e.rs = rs; e.alu = alu; e.pc4 = pc; e.rd = rd;
        e.rdata = erdata; e.mis = emis; e.berr = eberr; e.stalls = estalls;
        e.req = ereq; e.we = ewe; e.be = ebe; e.wd = ewd; e.addr = eaddr;
        ops_q.push_back(o);
        exps_q.push_back(e);
    endtask

    // Issues ops_q back-to-back; each expectation enters sb when its op is driven.
    task automatic run_stream();
        op_t cur; exp_t e; int stalls; bit done;
        int n = ops_q.size();
        drive(ops_q[0]);
        sb.push_back(exps_q[0]);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            cur = ops_q[i];
            if (i + 1 < n) begin
                drive(ops_q[i+1]);
                sb.push_back(exps_q[i+1]);
            end else begin
                drive_nop();
            end
            stalls = 0;
            done = 0;
            for (int k = 0; k < 40 && !done; k++) begin
                dmem_ack = (cur.ack_at == k);
                dmem_rdata = (cur.ack_at == k) ? cur.rdata : 32'hDEAD_BEEF;
                @(negedge clk);
                e = sb[0];
                if (RegWriteM === 1'b1) commits++;
                if (StallM === 1'b1) begin
                    stalls++;
                    checks++;
                    if (dmem_req !== 1'b1 || RegWriteM !== 1'b0 || ReadDataM !== 32'd0) begin
                        errors++;
                        $display("FAIL stall_outputs op%0d: req=%b rw=%b rd=%h want 1 0 0", i, dmem_req, RegWriteM, ReadDataM);
                    end
                    checks++;
                    if (dmem_addr !== e.addr || (e.we && (dmem_be !== e.be || dmem_wdata !== e.wd))) begin
                        errors++;
                        $display("FAIL stall_stable op%0d: addr=%h be=%b wd=%h want %h %b %h", i, dmem_addr, dmem_be, dmem_wdata, e.addr, e.be, e.wd);
                    end
                    @(posedge clk); #1;
                end else begin
                    void'(sb.pop_front());
                    done = 1;
                    checks++;
                    if (stalls != e.stalls) begin
                        errors++;
                        $display("FAIL stall_count op%0d: got %0d want %0d", i, stalls, e.stalls);
                    end
                    checks++;
                    if (RegWriteM !== e.rw) begin
                        errors++;
                        $display("FAIL regwrite op%0d: got %b want %b", i, RegWriteM, e.rw);
                    end
                    checks++;
                    if (ReadDataM !== e.rdata) begin
                        errors++;
                        $display("FAIL readdata op%0d: got %h want %h", i, ReadDataM, e.rdata);
                    end
                    checks++;
                    if (ALUResultM !== e.alu || PCPlus4M !== e.pc4 || RdM !== e.rd || ResultSrcM !== e.rs) begin
                        errors++;
                        $display("FAIL pipe_regs op%0d: alu=%h pc4=%h rd=%0d rs=%b want %h %h %0d %b", i, ALUResultM, PCPlus4M, RdM, ResultSrcM, e.alu, e.pc4, e.rd, e.rs);
                    end
                    checks++;
                    if (MisalignedM !== e.mis || BusErrorM !== e.berr) begin
                        errors++;
                        $display("FAIL faults op%0d: mis=%b berr=%b want %b %b", i, MisalignedM, BusErrorM, e.mis, e.berr);
                    end
                    if (!e.berr) begin
                        checks++;
                        if (dmem_req !== e.req) begin
                            errors++;
                            $display("FAIL req op%0d: got %b want %b", i, dmem_req, e.req);
                        end
                    end
                    if (e.req) begin
                        checks++;
                        if (dmem_we !== e.we || dmem_addr !== e.addr) begin
                            errors++;
                            $display("FAIL we_addr op%0d: we=%b addr=%h want %b %h", i, dmem_we, dmem_addr, e.we, e.addr);
                        end
                    end
                    if (e.we) begin
                        checks++;
                        if (dmem_be !== e.be || dmem_wdata !== e.wd) begin
                            errors++;
                            $display("FAIL store_lanes op%0d: be=%b wd=%h want %b %h", i, dmem_be, dmem_wdata, e.be, e.wd);
                        end
                    end
                end
            end
            if (!done) begin
                errors++;
                $display("FAIL no_completion op%0d: still stalled want done", i);
                if (sb.size() > 0) void'(sb.pop_front());
            end
            @(posedge clk); #1;
            dmem_ack = 0;
        end
        ops_q.delete();
        exps_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        checks++;
        if (RegWriteM !== 0 || ResultSrcM !== 0 || ALUResultM !== 0 || PCPlus4M !== 0 || RdM !== 0) begin
            errors++;
            $display("FAIL reset_regs: rw=%b rs=%b alu=%h pc4=%h rd=%0d want 0", RegWriteM, ResultSrcM, ALUResultM, PCPlus4M, RdM);
        end
        checks++;
        if (dmem_req !== 0 || StallM !== 0 || MisalignedM !== 0 || BusErrorM !== 0 || ReadDataM !== 0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b stall=%b mis=%b berr=%b rd=%h want 0", dmem_req, StallM, MisalignedM, BusErrorM, ReadDataM);
        end
        @(posedge clk); #1;
        RegWriteE = 1; MemWriteE = 0; ResultSrcE = 2'b01; funct3E = 3'b010;
        ALUResultE = 32'h600; WriteDataE = 0; PCPlus4E = 32'h44; RdE = 5'd6;
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        checks++;
        if (StallM !== 1 || dmem_req !== 1) begin
            errors++;
            $display("FAIL reset_pre_wait: stall=%b req=%b want 1 1", StallM, dmem_req);
        end
        @(posedge clk); #1;
        reset = 1;
        dmem_ack = 1;
        dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        reset = 0;
        dmem_ack = 0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 0 || StallM !== 0 || RegWriteM !== 0 || ReadDataM !== 0) begin
            errors++;
            $display("FAIL reset_wait: req=%b stall=%b rw=%b rd=%h want 0", dmem_req, StallM, RegWriteM, ReadDataM);
        end
        checks++;
        if (ALUResultM !== 0 || PCPlus4M !== 0 || RdM !== 0 || BusErrorM !== 0) begin
            errors++;
            $display("FAIL reset_wait_regs: alu=%h pc4=%h rd=%0d berr=%b want 0", ALUResultM, PCPlus4M, RdM, BusErrorM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        add(1, 0, 2'b01, 3'b000, 32'h103, 0, 5'd5, 0, 32'h80FF_FF12, 1, 32'hFFFF_FF80, 0, 0, 0, 1, 0, 4'b0, 32'h0, 32'h100);
        add(1, 0, 2'b01, 3'b100, 32'h103, 0, 5'd6, 0, 32'h80FF_FF12, 1, 32'h0000_0080, 0, 0, 0, 1, 0, 4'b0, 32'h0, 32'h100);
        add(1, 0, 2'b01, 3'b001, 32'h102, 0, 5'd7, 0, 32'h80FF_FF12, 1, 32'hFFFF_80FF, 0, 0, 0, 1, 0, 4'b0, 32'h0, 32'h100);
        add(1, 0, 2'b01, 3'b101, 32'h102, 0, 5'd8, 0, 32'h80FF_FF12, 1, 32'h0000_80FF, 0, 0, 0, 1, 0, 4'b0, 32'h0, 32'h100);
        add(1, 0, 2'b01, 3'b010, 32'h100, 0, 5'd9, 0, 32'h80FF_FF12, 1, 32'h80FF_FF12, 0, 0, 0, 1, 0, 4'b0, 32'h0, 32'h100);
        run_stream();
    endtask

    task automatic test_store_wait();
        add(0, 1, 2'b00, 3'b001, 32'h206, 32'h1234_ABCD, 5'd0, 3, 0, 0, 32'h0, 0, 0, 3, 1, 1, 4'b1100, 32'hABCD_ABCD, 32'h204);
        add(0, 1, 2'b00, 3'b000, 32'h301, 32'h0000_005A, 5'd0, 1, 0, 0, 32'h0, 0, 0, 1, 1, 1, 4'b0010, 32'h5A5A_5A5A, 32'h300);
        add(1, 0, 2'b00, 3'b000, 32'h999, 0, 5'd4, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0);
        run_stream();
    endtask

    task automatic test_misaligned();
        add(1, 0, 2'b01, 3'b010, 32'h102, 0, 5'd7, -1, 0, 0, 32'h0, 1, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0);
        add(0, 1, 2'b00, 3'b001, 32'h203, 32'h55, 5'd0, -1, 0, 0, 32'h0, 1, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0);
        add(1, 0, 2'b01, 3'b011, 32'h100, 0, 5'd3, -1, 0, 0, 32'h0, 1, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0);
        run_stream();
        @(negedge clk);
        checks++;
        if (MisalignedM !== 0) begin
            errors++;
            $display("FAIL misaligned_pulse: got %b want 0", MisalignedM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        add(1, 0, 2'b01, 3'b010, 32'h400, 0, 5'd9, -1, 0, 0, 32'h0, 0, 1, 4, 1, 0, 4'b0, 32'h0, 32'h400);
        run_stream();
        @(negedge clk);
        checks++;
        if (dmem_req !== 0 || BusErrorM !== 0 || StallM !== 0) begin
            errors++;
            $display("FAIL timeout_after: req=%b berr=%b stall=%b want 0", dmem_req, BusErrorM, StallM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = commits;
        add(1, 0, 2'b00, 3'b000, 32'h11, 0, 5'd1, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0);
        add(1, 0, 2'b01, 3'b010, 32'h500, 0, 5'd2, 1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0, 0, 1, 1, 0, 4'b0, 32'h0, 32'h500);
        add(0, 1, 2'b00, 3'b010, 32'h504, 32'h0102_0304, 5'd0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 4'b1111, 32'h0102_0304, 32'h504);
        add(1, 0, 2'b00, 3'b000, 32'h22, 0, 5'd3, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0);
        run_stream();
        checks++;
        if (commits - c0 != 3) begin
            errors++;
            $display("FAIL mixed_commits: got %0d want 3", commits - c0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        dmem_ack = 0;
        dmem_rdata = 0;
        drive_nop();
        test_reset();
        test_loads();
        test_store_wait();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
